// File: rtl/udp_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udp_rx_pkg
// Description : Shared types and protocol constants for the GMII UDP receiver
// Revision    : 1.0 - initial release
// ============================================================================
package udp_rx_pkg;

  // Receiver FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_ETH_HDR  = 3'd2,
    ST_IP_HDR   = 3'd3,
    ST_UDP_HDR  = 3'd4,
    ST_DATA     = 3'd5,
    ST_TAIL     = 3'd6,
    ST_DROP     = 3'd7
  } rx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] UDP_HDR_LEN   = 16'd8;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Last byte index of each fixed-length header, and FCS size
  localparam logic [15:0] ETH_HDR_LAST  = 16'd13;
  localparam logic [15:0] IP_HDR_LAST   = 16'd19;
  localparam logic [15:0] UDP_HDR_LAST  = 16'd7;
  localparam logic [15:0] FCS_LEN       = 16'd4;

  // Byte idx (0 = most significant, network order) of an nbytes-wide field
  function automatic logic [7:0] field_byte(input logic [47:0] value,
                                            input logic [2:0]  nbytes,
                                            input logic [2:0]  idx);
    logic [5:0]  sh;
    logic [47:0] shifted;
    sh      = {nbytes - 3'd1 - idx, 3'b000};
    shifted = value >> sh;
    return shifted[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/crc32_d8.sv
`default_nettype none
// ============================================================================
// Module      : crc32_d8
// Description : Byte-wide Ethernet CRC-32, reflected form, no final inversion
// Revision    : 1.0 - initial release
// ============================================================================
module crc32_d8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  localparam logic [31:0] c_POLY = 32'hEDB88320;
  localparam logic [31:0] c_SEED = 32'hFFFFFFFF;

  logic [31:0] w_next;

  // Fold one byte into the register, LSB first
  always_comb begin
    w_next = crc;
    for (int i = 0; i < 8; i++) begin
      w_next = (w_next[0] ^ data[i]) ? ((w_next >> 1) ^ c_POLY) : (w_next >> 1);
    end
  end

  // CRC register: seed on init, accumulate on en
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc <= c_SEED;
    end else if (init) begin
      crc <= c_SEED;
    end else if (en) begin
      crc <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/udp_receive.sv
`default_nettype none
// ============================================================================
// Module      : udp_receive
// Description : GMII Ethernet II / IPv4 / UDP receiver with MAC/IP/port
//               filtering, payload streaming and FCS-checked frame status
// Revision    : 1.0 - initial release
// ============================================================================
module udp_receive
  import udp_rx_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC  = 48'h00_0A_35_01_FE_C0,
  parameter logic [31:0] LOCAL_IP   = 32'hC0_A8_00_02,
  parameter logic [15:0] LOCAL_PORT = 16'd8080
) (
  input  logic        e_rxc,
  input  logic        rst_n,
  input  logic        e_rxdv,
  input  logic        e_rxer,
  input  logic [7:0]  e_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_data_valid,
  output logic        rx_frame_start,
  output logic        rx_frame_done,
  output logic        rx_frame_good,
  output logic [15:0] rx_data_length,
  output logic [31:0] rx_src_ip,
  output logic [15:0] rx_src_port
);

  rx_state_t   r_state, w_state_next;
  logic [15:0] r_cnt;
  logic        r_gap_seen;   // e_rxdv seen low since reset; blocks mid-frame starts
  logic        r_uc_ok, r_bc_ok, r_err;
  logic [31:0] r_src_ip;
  logic [15:0] r_src_port, r_udp_len;
  logic [31:0] w_crc;
  logic        w_sof, w_in_frame, w_da_uc, w_da_bc, w_byte_ok;
  logic        w_start, w_done, w_good, w_valid;
  logic [15:0] w_pay_len;

  assign w_sof      = (r_state == ST_PREAMBLE) && e_rxdv && (e_rxd == SFD_BYTE);
  assign w_in_frame = r_state inside {ST_ETH_HDR, ST_IP_HDR, ST_UDP_HDR, ST_DATA, ST_TAIL};
  assign w_da_uc    = r_uc_ok && (e_rxd == field_byte(LOCAL_MAC, 3'd6, r_cnt[2:0]));
  assign w_da_bc    = r_bc_ok && (e_rxd == 8'hFF);
  assign w_pay_len  = r_udp_len - UDP_HDR_LEN;

  crc32_d8 u_crc (
    .clk   (e_rxc),
    .rst_n (rst_n),
    .init  (w_sof),
    .en    (w_in_frame && e_rxdv),
    .data  (e_rxd),
    .crc   (w_crc)
  );

  // Per-byte header field acceptance
  always_comb begin
    w_byte_ok = 1'b1;
    case (r_state)
      ST_ETH_HDR: begin
        case (r_cnt)
          16'd0, 16'd1, 16'd2,
          16'd3, 16'd4, 16'd5: w_byte_ok = w_da_uc || w_da_bc;
          16'd12:              w_byte_ok = (e_rxd == ETH_TYPE_IPV4[15:8]);
          16'd13:              w_byte_ok = (e_rxd == ETH_TYPE_IPV4[7:0]);
          default:             w_byte_ok = 1'b1;
        endcase
      end
      ST_IP_HDR: begin
        case (r_cnt)
          16'd0:   w_byte_ok = (e_rxd == IP_VER_IHL);
          16'd9:   w_byte_ok = (e_rxd == IP_PROTO_UDP);
          16'd16, 16'd17, 16'd18, 16'd19:
                   w_byte_ok = (e_rxd == field_byte({16'h0, LOCAL_IP}, 3'd4, r_cnt[2:0]));
          default: w_byte_ok = 1'b1;
        endcase
      end
      ST_UDP_HDR: begin
        case (r_cnt)
          16'd2, 16'd3: w_byte_ok = (e_rxd == field_byte({32'h0, LOCAL_PORT}, 3'd2, {2'b00, r_cnt[0]}));
          16'd5:        w_byte_ok = ({r_udp_len[7:0], e_rxd} >= UDP_HDR_LEN);
          default:      w_byte_ok = 1'b1;
        endcase
      end
      default: w_byte_ok = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge e_rxc) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:
        if (e_rxdv && r_gap_seen && (e_rxd == PREAMBLE_BYTE)) w_state_next = ST_PREAMBLE;
      ST_PREAMBLE:
        if (!e_rxdv)                    w_state_next = ST_IDLE;
        else if (e_rxd == SFD_BYTE)     w_state_next = ST_ETH_HDR;
        else if (e_rxd != PREAMBLE_BYTE) w_state_next = ST_DROP;
      ST_ETH_HDR:
        if (!e_rxdv)                    w_state_next = ST_IDLE;
        else if (!w_byte_ok)            w_state_next = ST_DROP;
        else if (r_cnt == ETH_HDR_LAST) w_state_next = ST_IP_HDR;
      ST_IP_HDR:
        if (!e_rxdv)                    w_state_next = ST_IDLE;
        else if (!w_byte_ok)            w_state_next = ST_DROP;
        else if (r_cnt == IP_HDR_LAST)  w_state_next = ST_UDP_HDR;
      ST_UDP_HDR:
        if (!e_rxdv)                    w_state_next = ST_IDLE;
        else if (!w_byte_ok)            w_state_next = ST_DROP;
        else if (r_cnt == UDP_HDR_LAST) w_state_next = (w_pay_len == 16'd0) ? ST_TAIL : ST_DATA;
      ST_DATA:
        if (!e_rxdv)                                   w_state_next = ST_IDLE;
        else if (r_cnt == rx_data_length - 16'd1)      w_state_next = ST_TAIL;
      ST_TAIL, ST_DROP:
        if (!e_rxdv) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Output decode; registered below so every port is a flop
  always_comb begin
    w_valid = (r_state == ST_DATA) && e_rxdv;
    w_start = (r_state == ST_UDP_HDR) && e_rxdv && (r_cnt == UDP_HDR_LAST);
    w_done  = ((r_state == ST_DATA) || (r_state == ST_TAIL)) && !e_rxdv;
    w_good  = (r_state == ST_TAIL) && !e_rxdv && (w_crc == CRC_RESIDUE)
              && !r_err && (r_cnt >= FCS_LEN);
  end

  // Byte counter, DA match tracking, error flag and header field capture
  always_ff @(posedge e_rxc) begin
    if (!rst_n) begin
      r_cnt      <= 16'd0;
      r_gap_seen <= 1'b0;
      r_uc_ok    <= 1'b0;
      r_bc_ok    <= 1'b0;
      r_err      <= 1'b0;
      r_src_ip   <= 32'd0;
      r_src_port <= 16'd0;
      r_udp_len  <= 16'd0;
    end else begin
      if (!e_rxdv) r_gap_seen <= 1'b1;

      if (w_state_next != r_state)         r_cnt <= 16'd0;
      else if (e_rxdv && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;

      if (w_sof) begin
        r_uc_ok <= 1'b1;
        r_bc_ok <= 1'b1;
        r_err   <= 1'b0;
      end else begin
        if ((r_state == ST_ETH_HDR) && e_rxdv && (r_cnt < 16'd6)) begin
          r_uc_ok <= w_da_uc;
          r_bc_ok <= w_da_bc;
        end
        if (w_in_frame && e_rxdv && e_rxer) r_err <= 1'b1;
      end

      if ((r_state == ST_IP_HDR) && e_rxdv && (r_cnt >= 16'd12) && (r_cnt <= 16'd15))
        r_src_ip <= {r_src_ip[23:0], e_rxd};

      if ((r_state == ST_UDP_HDR) && e_rxdv) begin
        if (r_cnt <= 16'd1)                       r_src_port <= {r_src_port[7:0], e_rxd};
        if ((r_cnt == 16'd4) || (r_cnt == 16'd5)) r_udp_len  <= {r_udp_len[7:0], e_rxd};
      end
    end
  end

  // Registered outputs
  always_ff @(posedge e_rxc) begin
    if (!rst_n) begin
      rx_data        <= 8'd0;
      rx_data_valid  <= 1'b0;
      rx_frame_start <= 1'b0;
      rx_frame_done  <= 1'b0;
      rx_frame_good  <= 1'b0;
      rx_data_length <= 16'd0;
      rx_src_ip      <= 32'd0;
      rx_src_port    <= 16'd0;
    end else begin
      rx_data_valid  <= w_valid;
      rx_frame_start <= w_start;
      rx_frame_done  <= w_done;
      rx_frame_good  <= w_good;
      if (w_valid) rx_data <= e_rxd;
      if (w_start) begin
        rx_data_length <= w_pay_len;
        rx_src_ip      <= r_src_ip;
        rx_src_port    <= r_src_port;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_udp_receive.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_udp_receive
// Description : Self-checking bench for udp_receive; frames built from field
//               values, expectations derived from frame contents
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udp_receive;

  localparam logic [47:0] MAC  = 48'h000A3501FEC0;
  localparam logic [47:0] BCST = 48'hFFFFFFFFFFFF;
  localparam logic [31:0] IP   = 32'hC0A80002;
  localparam logic [15:0] PORT = 16'd8080;

  typedef logic [7:0] bq_t[$];
  typedef struct { int cyc; logic [15:0] len; logic [31:0] ip; logic [15:0] port; } start_t;
  typedef struct { int cyc; logic good; } done_t;

  logic        e_rxc = 1'b0, rst_n = 1'b0, e_rxdv = 1'b0, e_rxer = 1'b0;
  logic [7:0]  e_rxd = 8'h00;
  logic [7:0]  rx_data;
  logic        rx_data_valid, rx_frame_start, rx_frame_done, rx_frame_good;
  logic [15:0] rx_data_length, rx_src_port;
  logic [31:0] rx_src_ip;

  int checks = 0, errors = 0, cyc = 0;

  logic [7:0] act_vdata[$], exp_vdata[$];
  int         act_vcyc[$],  exp_vcyc[$];
  start_t     act_st[$],    exp_st[$];
  done_t      act_dn[$],    exp_dn[$];

  udp_receive dut (
    .e_rxc(e_rxc), .rst_n(rst_n), .e_rxdv(e_rxdv), .e_rxer(e_rxer), .e_rxd(e_rxd),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid), .rx_frame_start(rx_frame_start),
    .rx_frame_done(rx_frame_done), .rx_frame_good(rx_frame_good),
    .rx_data_length(rx_data_length), .rx_src_ip(rx_src_ip), .rx_src_port(rx_src_port)
  );

  always #4 e_rxc = ~e_rxc;
  always @(posedge e_rxc) cyc++;

  // Record every DUT output event with the cycle it appeared in
  always @(negedge e_rxc) begin
    start_t s;
    done_t  d;
    if (rx_data_valid) begin
      act_vdata.push_back(rx_data);
      act_vcyc.push_back(cyc);
    end
    if (rx_frame_start) begin
      s.cyc = cyc; s.len = rx_data_length; s.ip = rx_src_ip; s.port = rx_src_port;
      act_st.push_back(s);
    end
    if (rx_frame_done) begin
      d.cyc = cyc; d.good = rx_frame_good;
      act_dn.push_back(d);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Standard Ethernet FCS value of the first n bytes
  function automatic logic [31:0] fcs32(input bq_t b, input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, b[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Frame from DA to FCS (preamble/SFD added by send)
  task automatic build(input logic [47:0] da, input logic [31:0] dip, input logic [15:0] dport,
                       input logic [31:0] sip, input logic [15:0] sport, input bq_t pay,
                       input int npad, output bq_t f);
    logic [15:0] ulen, tlen;
    logic [31:0] fcs;
    f = {};
    ulen = 16'(pay.size() + 8);
    tlen = ulen + 16'd20;
    for (int i = 5; i >= 0; i--) f.push_back(da[8*i +: 8]);
    f.push_back(8'h02); for (int i = 0; i < 4; i++) f.push_back(8'h00); f.push_back(8'h01);
    f.push_back(8'h08); f.push_back(8'h00);
    f.push_back(8'h45); f.push_back(8'h00); f.push_back(tlen[15:8]); f.push_back(tlen[7:0]);
    f.push_back(8'h00); f.push_back(8'h00); f.push_back(8'h40); f.push_back(8'h00);
    f.push_back(8'h40); f.push_back(8'h11); f.push_back(8'h00); f.push_back(8'h00);
    for (int i = 3; i >= 0; i--) f.push_back(sip[8*i +: 8]);
    for (int i = 3; i >= 0; i--) f.push_back(dip[8*i +: 8]);
    f.push_back(sport[15:8]); f.push_back(sport[7:0]);
    f.push_back(dport[15:8]); f.push_back(dport[7:0]);
    f.push_back(ulen[15:8]);  f.push_back(ulen[7:0]);
    f.push_back(8'h00); f.push_back(8'h00);
    foreach (pay[i]) f.push_back(pay[i]);
    for (int i = 0; i < npad; i++) f.push_back(8'h00);
    fcs = fcs32(f, f.size());
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
  endtask

  // Drive preamble, SFD and the first n frame bytes; optional e_rxer byte and reset window
  task automatic send(input bq_t f, input int n, input int rxer_idx, input int rst_idx,
                      output int base);
    base = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge e_rxc); #1;
      e_rxdv = 1'b1; e_rxer = 1'b0;
      e_rxd  = (i == 7) ? 8'hD5 : 8'h55;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge e_rxc); #1;
      if (i == 0) base = cyc;
      e_rxd  = f[i];
      e_rxer = (i == rxer_idx);
      if (rst_idx >= 0 && i == rst_idx) rst_n = 1'b0;
      if (rst_idx >= 0 && i == rst_idx + 2) begin
        check("midframe_reset_a", 64'({rx_data, rx_data_valid, rx_frame_start, rx_frame_done,
                                        rx_frame_good, rx_data_length}), 64'd0);
        check("midframe_reset_b", 64'({rx_src_ip, rx_src_port}), 64'd0);
        rst_n = 1'b1;
      end
    end
    @(posedge e_rxc); #1;
    e_rxdv = 1'b0; e_rxer = 1'b0; e_rxd = 8'h00;
  endtask

  // Expected DUT behaviour from the frame's field values and what was actually sent
  task automatic model(input bq_t f, input int n, input int base, input int rxer_idx);
    logic   acc, good;
    int     ulen, plen, nout;
    start_t s;
    done_t  d;
    if (n < 42) return;
    ulen = int'({f[38], f[39]});
    acc  = (({f[0], f[1], f[2], f[3], f[4], f[5]} == MAC) ||
            ({f[0], f[1], f[2], f[3], f[4], f[5]} == BCST)) &&
           ({f[12], f[13]} == 16'h0800) && (f[14] == 8'h45) && (f[23] == 8'h11) &&
           ({f[30], f[31], f[32], f[33]} == IP) && ({f[36], f[37]} == PORT) && (ulen >= 8);
    if (!acc) return;
    plen = ulen - 8;
    s.cyc = base + 42; s.len = 16'(plen);
    s.ip = {f[26], f[27], f[28], f[29]}; s.port = {f[34], f[35]};
    exp_st.push_back(s);
    nout = (n - 42 < plen) ? (n - 42) : plen;
    for (int k = 0; k < nout; k++) begin
      exp_vdata.push_back(f[42 + k]);
      exp_vcyc.push_back(base + 42 + k + 1);
    end
    good = (n >= 42 + plen + 4) && !(rxer_idx >= 0 && rxer_idx < n) &&
           (fcs32(f, n - 4) == {f[n-1], f[n-2], f[n-3], f[n-4]});
    d.cyc = base + n + 1; d.good = good;
    exp_dn.push_back(d);
  endtask

  task automatic verify(input string tag);
    repeat (3) @(posedge e_rxc);
    #1;
    check({tag, ":n_valid"}, 64'(act_vdata.size()), 64'(exp_vdata.size()));
    for (int i = 0; i < exp_vdata.size() && i < act_vdata.size(); i++) begin
      check({tag, ":data"},     64'(act_vdata[i]), 64'(exp_vdata[i]));
      check({tag, ":data_cyc"}, 64'(act_vcyc[i]),  64'(exp_vcyc[i]));
    end
    check({tag, ":n_start"}, 64'(act_st.size()), 64'(exp_st.size()));
    for (int i = 0; i < exp_st.size() && i < act_st.size(); i++) begin
      check({tag, ":start_cyc"}, 64'(act_st[i].cyc),  64'(exp_st[i].cyc));
      check({tag, ":length"},    64'(act_st[i].len),  64'(exp_st[i].len));
      check({tag, ":src_ip"},    64'(act_st[i].ip),   64'(exp_st[i].ip));
      check({tag, ":src_port"},  64'(act_st[i].port), 64'(exp_st[i].port));
    end
    check({tag, ":n_done"}, 64'(act_dn.size()), 64'(exp_dn.size()));
    for (int i = 0; i < exp_dn.size() && i < act_dn.size(); i++) begin
      check({tag, ":done_cyc"}, 64'(act_dn[i].cyc),  64'(exp_dn[i].cyc));
      check({tag, ":good"},     64'(act_dn[i].good), 64'(exp_dn[i].good));
    end
    act_vdata = {}; act_vcyc = {}; act_st = {}; act_dn = {};
    exp_vdata = {}; exp_vcyc = {}; exp_st = {}; exp_dn = {};
  endtask

  task automatic rand_payload(input int len, output bq_t p);
    p = {};
    for (int i = 0; i < len; i++) p.push_back(8'($urandom));
  endtask

  initial begin
    bq_t f, g, pay, inner;
    int  base, plen;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge e_rxc);
    #1;
    check("reset_a", 64'({rx_data, rx_data_valid, rx_frame_start, rx_frame_done,
                          rx_frame_good, rx_data_length}), 64'd0);
    check("reset_b", 64'({rx_src_ip, rx_src_port}), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge e_rxc);

    // Good unicast frame, payload 0x00..0x1F
    pay = {};
    for (int i = 0; i < 32; i++) pay.push_back(8'(i));
    build(MAC, IP, PORT, 32'hC0A80003, 16'd5000, pay, 0, f);
    send(f, f.size(), -1, -1, base);
    model(f, f.size(), base, -1);
    verify("unicast32");

    // Wrong destination IP, then a good frame one idle cycle later
    build(MAC, 32'hC0A80009, PORT, 32'hC0A80003, 16'd5000, pay, 0, f);
    send(f, f.size(), -1, -1, base);
    model(f, f.size(), base, -1);
    rand_payload(20, pay);
    build(MAC, IP, PORT, 32'hC0A80005, 16'd1234, pay, 0, f);
    send(f, f.size(), -1, -1, base);
    model(f, f.size(), base, -1);
    verify("bad_ip_then_good");

    // Minimum frame with padding, then broadcast frame with a corrupted payload bit
    rand_payload(4, pay);
    build(MAC, IP, PORT, 32'hC0A80003, 16'd5000, pay, 14, f);
    send(f, f.size(), -1, -1, base);
    model(f, f.size(), base, -1);
    rand_payload(16, pay);
    build(BCST, IP, PORT, 32'hC0A80007, 16'd77, pay, 2, f);
    f[42 + 7] = f[42 + 7] ^ 8'h04;
    send(f, f.size(), -1, -1, base);
    model(f, f.size(), base, -1);
    verify("pad_and_bad_fcs");

    // e_rxer on payload byte 10
    rand_payload(24, pay);
    build(MAC, IP, PORT, 32'hC0A80003, 16'd5000, pay, 0, f);
    send(f, f.size(), 42 + 10, -1, base);
    model(f, f.size(), base, 42 + 10);
    verify("rxer");

    // e_rxdv dropped after payload byte 5
    rand_payload(16, pay);
    build(MAC, IP, PORT, 32'hC0A80003, 16'd5000, pay, 0, f);
    send(f, 42 + 5, -1, -1, base);
    model(f, 42 + 5, base, -1);
    verify("truncated");

    // Reset during IP header; the rest of that frame carries a complete embedded
    // frame which must not be picked up
    rand_payload(6, pay);
    build(MAC, IP, PORT, 32'hC0A80004, 16'd4000, pay, 0, inner);
    g = {};
    for (int i = 0; i < 7; i++) g.push_back(8'h55);
    g.push_back(8'hD5);
    foreach (inner[i]) g.push_back(inner[i]);
    build(MAC, IP, PORT, 32'hC0A80003, 16'd5000, g, 0, f);
    send(f, f.size(), -1, 20, base);
    verify("reset_frame");
    repeat (2) @(posedge e_rxc);
    rand_payload(12, pay);
    build(MAC, IP, PORT, 32'hC0A80003, 16'd5000, pay, 0, f);
    send(f, f.size(), -1, -1, base);
    model(f, f.size(), base, -1);
    verify("after_reset");

    // Random back-to-back frames, first one with an empty payload
    for (int r = 0; r < 4; r++) begin
      plen = (r == 0) ? 0 : int'($urandom_range(1, 40));
      rand_payload(plen, pay);
      build(($urandom_range(0, 1) == 0) ? MAC : BCST, IP, PORT, $urandom,
            16'($urandom), pay, (plen < 18) ? (18 - plen) : 0, f);
      send(f, f.size(), -1, -1, base);
      model(f, f.size(), base, -1);
    end
    verify("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
